// File: rtl/hsv_pkg.sv
// rtl/hsv_pkg.sv - shared constants and sector encoding for the HSV to RGB pipeline
package hsv_pkg;

    localparam int H_W         = 9;
    localparam int F_W         = 6;
    localparam int H_MAX       = 359;
    localparam int SECTOR_DEG  = 60;
    localparam int RECIP60     = 1093;
    localparam int RECIP_W     = 11;
    localparam int RECIP_SH    = 16;
    localparam int HSV2RGB_LAT = 4;

    // One code per 60-degree hue sector, named by the colours it spans.
    typedef enum logic [2:0] {
        SEC_RY = 3'd0,
        SEC_YG = 3'd1,
        SEC_GC = 3'd2,
        SEC_CB = 3'd3,
        SEC_BM = 3'd4,
        SEC_MR = 3'd5
    } sector_t;

endpackage

// File: rtl/hsv_sector_decode.sv
// rtl/hsv_sector_decode.sv - first pipeline stage: hue clamp, sector ladder and in-sector fraction
module hsv_sector_decode
    import hsv_pkg::*;
#(
    parameter int S_W = 11,
    parameter int V_W = 8
) (
    input  logic           clk,
    input  logic [H_W-1:0] hue,
    input  logic [S_W-1:0] sat,
    input  logic [V_W-1:0] val,
    output sector_t        sector,
    output logic [F_W-1:0] frac,
    output logic [S_W-1:0] sat_q,
    output logic [V_W-1:0] val_q
);

    logic [H_W-1:0] hue_c;
    logic [H_W-1:0] base;
    sector_t        sector_n;

    // Compare ladder instead of a divider; base is the first degree of the chosen sector.
    always_comb begin
        hue_c    = (hue > H_W'(H_MAX)) ? H_W'(H_MAX) : hue;
        sector_n = SEC_RY;
        base     = '0;
        if (hue_c >= H_W'(5 * SECTOR_DEG)) begin
            sector_n = SEC_MR;
            base     = H_W'(5 * SECTOR_DEG);
        end else if (hue_c >= H_W'(4 * SECTOR_DEG)) begin
            sector_n = SEC_BM;
            base     = H_W'(4 * SECTOR_DEG);
        end else if (hue_c >= H_W'(3 * SECTOR_DEG)) begin
            sector_n = SEC_CB;
            base     = H_W'(3 * SECTOR_DEG);
        end else if (hue_c >= H_W'(2 * SECTOR_DEG)) begin
            sector_n = SEC_GC;
            base     = H_W'(2 * SECTOR_DEG);
        end else if (hue_c >= H_W'(SECTOR_DEG)) begin
            sector_n = SEC_YG;
            base     = H_W'(SECTOR_DEG);
        end
    end

    always_ff @(posedge clk) begin
        sector <= sector_n;
        frac   <= F_W'(hue_c - base);
        sat_q  <= sat;
        val_q  <= val;
    end

endmodule

// File: rtl/hsv_to_rgb_pipe.sv
// rtl/hsv_to_rgb_pipe.sv - four-stage HSV to 8-bit RGB converter with frame sideband
module hsv_to_rgb_pipe
    import hsv_pkg::*;
#(
    parameter int S_W = 11,
    parameter int V_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic           in_sof,
    input  logic           in_eol,
    input  logic [H_W-1:0] H_in,
    input  logic [S_W-1:0] S_in,
    input  logic [V_W-1:0] V_in,
    output logic           out_valid,
    output logic           out_sof,
    output logic           out_eol,
    output logic [V_W-1:0] R_out,
    output logic [V_W-1:0] G_out,
    output logic [V_W-1:0] B_out
);

    localparam int VS_W = V_W + S_W;
    localparam int UP_W = V_W + F_W + RECIP_W;

    sector_t        s1_sector;
    logic [F_W-1:0] s1_frac;
    logic [S_W-1:0] s1_sat;
    logic [V_W-1:0] s1_val;

    sector_t        s2_sector;
    logic [F_W-1:0] s2_frac;
    logic [V_W-1:0] s2_val;
    logic [V_W-1:0] s2_c;

    sector_t        s3_sector;
    logic [V_W-1:0] s3_val;
    logic [V_W-1:0] s3_m;
    logic [V_W-1:0] s3_rise;
    logic [V_W-1:0] s3_fall;

    logic [VS_W-1:0] vs_prod;
    logic [UP_W-1:0] up_prod;
    logic [V_W-1:0]  up;
    logic [V_W-1:0]  m;
    logic [V_W-1:0]  r_n;
    logic [V_W-1:0]  g_n;
    logic [V_W-1:0]  b_n;

    logic [HSV2RGB_LAT-1:0] vld_sr;
    logic [HSV2RGB_LAT-1:0] sof_sr;
    logic [HSV2RGB_LAT-1:0] eol_sr;

    hsv_sector_decode #(
        .S_W(S_W),
        .V_W(V_W)
    ) u_sector_decode (
        .clk   (clk),
        .hue   (H_in),
        .sat   (S_in),
        .val   (V_in),
        .sector(s1_sector),
        .frac  (s1_frac),
        .sat_q (s1_sat),
        .val_q (s1_val)
    );

    // Chroma: full-scale S is 2^S_W, so 2047 lands one LSB short of V.
    assign vs_prod = VS_W'(s1_val) * VS_W'(s1_sat);

    always_ff @(posedge clk) begin
        s2_c      <= V_W'(vs_prod >> S_W);
        s2_frac   <= s2_frac_next();
        s2_sector <= s1_sector;
        s2_val    <= s1_val;
    end

    function automatic logic [F_W-1:0] s2_frac_next();
        return s1_frac;
    endfunction

    // f/60 as f*1093>>16; f <= 59 keeps up <= C, so rise/fall never wrap.
    assign up_prod = UP_W'(s2_c) * UP_W'(s2_frac) * UP_W'(RECIP60);
    assign up      = V_W'(up_prod >> RECIP_SH);
    assign m       = s2_val - s2_c;

    always_ff @(posedge clk) begin
        s3_m      <= m;
        s3_rise   <= m + up;
        s3_fall   <= s2_val - up;
        s3_val    <= s2_val;
        s3_sector <= s2_sector;
    end

    always_comb begin
        r_n = s3_val;
        g_n = s3_val;
        b_n = s3_val;
        case (s3_sector)
            SEC_RY: begin r_n = s3_val;  g_n = s3_rise; b_n = s3_m;    end
            SEC_YG: begin r_n = s3_fall; g_n = s3_val;  b_n = s3_m;    end
            SEC_GC: begin r_n = s3_m;    g_n = s3_val;  b_n = s3_rise; end
            SEC_CB: begin r_n = s3_m;    g_n = s3_fall; b_n = s3_val;  end
            SEC_BM: begin r_n = s3_rise; g_n = s3_m;    b_n = s3_val;  end
            SEC_MR: begin r_n = s3_val;  g_n = s3_m;    b_n = s3_fall; end
            default: begin r_n = s3_val; g_n = s3_val;  b_n = s3_val;  end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            R_out <= '0;
            G_out <= '0;
            B_out <= '0;
        end else begin
            R_out <= r_n;
            G_out <= g_n;
            B_out <= b_n;
        end
    end

    // sof/eol are masked on entry, so every stage holds them low whenever its valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            sof_sr <= '0;
            eol_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[HSV2RGB_LAT-2:0], in_valid};
            sof_sr <= {sof_sr[HSV2RGB_LAT-2:0], in_valid & in_sof};
            eol_sr <= {eol_sr[HSV2RGB_LAT-2:0], in_valid & in_eol};
        end
    end

    assign out_valid = vld_sr[HSV2RGB_LAT-1];
    assign out_sof   = sof_sr[HSV2RGB_LAT-1];
    assign out_eol   = eol_sr[HSV2RGB_LAT-1];

endmodule
